// File: rtl/clock_divider_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clock_divider_multi                                                      |
// | Multi-channel programmable clock divider with glitch-free divisor update |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module clock_divider_multi #(
  parameter int NUM_CH      = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 3,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    enable,
  input  logic                 div_load,
  input  logic [CH_W-1:0]      div_ch,
  input  logic [DIV_WIDTH-1:0] div_value,
  output logic [NUM_CH-1:0]    clk_out,
  output logic [NUM_CH-1:0]    tick,
  output logic [NUM_CH-1:0]    pending
);

  localparam logic [DIV_WIDTH-1:0] c_one       = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] c_reset_div =
      (DEFAULT_DIV < 1) ? DIV_WIDTH'(1) : DIV_WIDTH'(DEFAULT_DIV);

  logic [DIV_WIDTH-1:0] w_load_val;

  // A zero half-period would stall the counter, so it is treated as 1.
  assign w_load_val = (div_value == '0) ? c_one : div_value;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [DIV_WIDTH-1:0] r_half;
    logic [DIV_WIDTH-1:0] r_next_half;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 r_out;
    logic                 r_tick;
    logic                 r_pend;
    logic                 w_sel;
    logic                 w_wrap;
    logic                 w_apply;

    // Out-of-range channel numbers match no channel, so such writes vanish.
    assign w_sel   = div_load && (div_ch == CH_W'(gi));
    assign w_wrap  = (r_cnt >= (r_half - c_one));
    assign w_apply = r_pend && (!enable[gi] || (w_wrap && r_out));

    always_ff @(posedge clk_in) begin
      if (reset) begin
        r_half      <= c_reset_div;
        r_next_half <= c_reset_div;
        r_cnt       <= '0;
        r_out       <= 1'b0;
        r_tick      <= 1'b0;
        r_pend      <= 1'b0;
      end else begin
        if (!enable[gi]) begin
          r_cnt  <= '0;
          r_out  <= 1'b0;
          r_tick <= 1'b0;
        end else if (w_wrap) begin
          r_cnt  <= '0;
          r_out  <= ~r_out;
          r_tick <= ~r_out;
        end else begin
          r_cnt  <= r_cnt + c_one;
          r_tick <= 1'b0;
        end

        if (w_apply) begin
          r_half <= r_next_half;
          r_pend <= 1'b0;
        end

        // Placed after the apply so a same-cycle write stays pending.
        if (w_sel) begin
          r_next_half <= w_load_val;
          r_pend      <= 1'b1;
        end
      end
    end

    assign clk_out[gi] = r_out;
    assign tick[gi]    = r_tick;
    assign pending[gi] = r_pend;
  end

endmodule
`default_nettype wire

// File: doc/clock_divider_multi.md
Name: clock_divider_multi

Overview:
- Parametrised, multi-channel successor to the fixed 50 MHz divide-down clock generator.
- Each channel has its own runtime-programmable half-period divisor, an enable, and a one-cycle rising-edge tick strobe.
- Divisor changes are glitch-free: they are held pending and applied only at a period boundary.
- Sits beside the system clock input and feeds slow clock/strobe domains (PWM, encoder sampling, step timing).

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- DIV_WIDTH, 16, width of the half-period divisor and counters.
- DEFAULT_DIV, 3, half-period loaded into every channel at reset. 3 gives clk_in/6.

Ports:
- clk_in  input  1  system clock (50 MHz); all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  NUM_CH  per-channel run enable, level sensitive.
- div_load  input  1  single-cycle write strobe for a new divisor.
- div_ch  input  $clog2(NUM_CH) (min 1)  channel targeted by div_load.
- div_value  input  DIV_WIDTH  requested half-period in clk_in cycles.
- clk_out  output  NUM_CH  divided clocks, registered.
- tick  output  NUM_CH  one-clk_in-cycle pulse, high during the first clk_in cycle in which clk_out[i] is high.
- pending  output  NUM_CH  1 = a loaded divisor is awaiting application on that channel.

Behaviour:
- Reset (reset=1 at a clk_in edge, wins over all other inputs):
  - clk_out=0, tick=0, pending=0.
  - Every counter=0; every active divisor = DEFAULT_DIV.
  - Reset mid-period truncates the period immediately, with no completion.
- Per-channel state:
  - active half-period H (DIV_WIDTH bits), pending value P, pending flag, counter C, output register O.
- Running (enable[i]=1):
  - If C < H-1: C <= C+1.
  - Else: C <= 0 and O toggles. The output period is therefore 2*H clk_in cycles, with 50% duty.
  - tick[i] is registered. It is 1 exactly in the cycle where O has just gone 0->1, otherwise 0.
- First edge after enable rises from 0:
  - clk_out first goes high H cycles after the first cycle with enable=1 (C starts from 0).
- Disabled (enable[i]=0):
  - C <= 0, O <= 0, tick <= 0 on the next edge. This forces the clock low immediately, and a truncated high phase is allowed.
- Divisor write:
  - On div_load=1 with div_ch < NUM_CH: P[div_ch] <= div_value and pending[div_ch] <= 1.
  - div_value=0 is clamped to 1.
  - div_ch >= NUM_CH: the write is ignored and no state changes.
- Apply point (glitch-free): when the pending flag is set, H <= P and the pending flag clears at either of these:
  - (a) the cycle O toggles 1->0, i.e. a full period completes; C restarts at 0 under the new H;
  - (b) any cycle in which the channel is disabled.
- Write in the same cycle as an apply on the same channel:
  - The old P is applied and the new value becomes P with pending still set.
  - The newest write is never lost.
- Multiple writes before an apply: last write wins.
- H=1: clk_out = clk_in/2, tick every second cycle.
- H = 2^DIV_WIDTH-1: the counter reaches H-1 without overflow, and no wrap-around error is allowed.
- Channels are fully independent; there is no cross-channel phase alignment.
- Latency from reset release with enable=1 to the first clk_out high: H clk_in cycles.

Test Plan:
- Reset, enable[0]=1, default DIV=3 -> clk_out[0] rises 3 cycles after enable, period 6, high 3/low 3; tick[0] pulses once per 6 cycles, aligned to the rise.
- Load ch1=5 while ch1 runs at H=3 mid-high-phase -> pending[1]=1; the current period completes at 6 cycles; the next periods are 10 cycles; pending clears on the 1->0 toggle; no pulse shorter than 3 cycles.
- Load ch2=0 -> H=1, clk_out[2] toggles every cycle (clk_in/2), tick every 2 cycles; load div_ch=NUM_CH -> all outputs and pending unchanged.
- enable[3] dropped while clk_out[3]=1 with pending set -> clk_out[3]=0 next cycle, pending[3] clears, new H in effect; re-enable -> first rise after new H cycles.
- Same-cycle load and 1->0 apply on ch0 (P=4 pending, write 7) -> H becomes 4, P=7, pending stays 1, and 7 applies at the next period end.
- Assert reset mid-high-phase on all channels -> next edge: all clk_out=0, tick=0, pending=0, H=DEFAULT_DIV.
